// File: rtl/sprite_line_scheduler.sv
// Renders one scanline of sprites into the back bank of a ping-pong line buffer.
// Define SPRITE_LINE_CLEAR_EN to clear the back bank to BG_COLOR before each render.
module sprite_line_scheduler #(
  parameter int unsigned NUM_SPRITES = 20,
  parameter int unsigned SPRITE_SIZE = 32,
  parameter logic [23:0] TRANSPARENT = 24'h000000,
  parameter logic [23:0] BG_COLOR    = 24'h000000,
  localparam int unsigned CW = $clog2(SPRITE_SIZE),
  localparam int unsigned IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [24*NUM_SPRITES-1:0] gl_array_i,
  input  logic                      start_i,
  input  logic [9:0]                line_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      overrun_o,
  output logic                      rom_req_o,
  output logic [5+2*CW-1:0]         rom_addr_o,
  input  logic                      rom_ack_i,
  input  logic [23:0]               rom_data_i,
  output logic                      lb_we_o,
  output logic                      lb_bank_o,
  output logic [9:0]                lb_addr_o,
  output logic [23:0]               lb_data_o
);

  typedef enum logic [2:0] {StIdle, StClear, StScan, StFetch, StWrite, StDone} state_e;

  state_e             state_q;
  logic [9:0]         line_q;
  logic [IW-1:0]      idx_q;
  logic [4:0]         type_q;
  logic [9:0]         x_q;
  logic [CW-1:0]      row_q;
  logic [CW-1:0]      col_q;
  logic               busy_q, done_q, overrun_q, bank_q;
  logic               rom_req_q;
  logic [5+2*CW-1:0]  rom_addr_q;
  logic               lb_we_q;
  logic [9:0]         lb_addr_q;
  logic [23:0]        lb_data_q;

  // Table entry under inspection is read live; only the hit entry gets latched.
  logic [23:0] entry;
  logic [4:0]  e_type;
  logic [9:0]  e_x, e_y, diff;
  logic        hit, last_entry, visible;
  logic [10:0] pix_x;

  always_comb begin
    entry      = gl_array_i[idx_q*24 +: 24];
    e_type     = entry[23:19];
    e_x        = entry[18:9];
    e_y        = {1'b0, entry[8:0]};
    diff       = line_q - e_y;
    hit        = (e_type != 5'd0) && (line_q >= e_y) && (diff < 10'(SPRITE_SIZE));
    last_entry = (idx_q == IW'(NUM_SPRITES - 1));
    pix_x      = {1'b0, x_q} + 11'(col_q);
    visible    = (pix_x <= 11'd639);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      line_q     <= '0;
      idx_q      <= '0;
      type_q     <= '0;
      x_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      bank_q     <= 1'b0;
      rom_req_q  <= 1'b0;
      rom_addr_q <= '0;
      lb_we_q    <= 1'b0;
      lb_addr_q  <= '0;
      lb_data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        // A start outside IDLE/DONE aborts the render in flight.
        if (state_q != StIdle && state_q != StDone) overrun_q <= 1'b1;
        line_q    <= line_i;
        bank_q    <= ~bank_q;
        busy_q    <= 1'b1;
        rom_req_q <= 1'b0;
        idx_q     <= '0;
`ifdef SPRITE_LINE_CLEAR_EN
        state_q   <= StClear;
        lb_we_q   <= 1'b1;
        lb_addr_q <= '0;
        lb_data_q <= BG_COLOR;
`else
        state_q   <= StScan;
        lb_we_q   <= 1'b0;
`endif
      end else begin
        unique case (state_q)
          StIdle: ;
`ifdef SPRITE_LINE_CLEAR_EN
          StClear: begin
            if (lb_addr_q == 10'd639) begin
              lb_we_q <= 1'b0;
              state_q <= StScan;
            end else begin
              lb_addr_q <= lb_addr_q + 10'd1;
            end
          end
`endif
          StScan: begin
            if (hit) begin
              type_q  <= e_type;
              x_q     <= e_x;
              row_q   <= diff[CW-1:0];
              col_q   <= '0;
              state_q <= StFetch;
            end else if (last_entry) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StDone;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          StFetch: begin
            if (!rom_req_q) begin
              rom_req_q  <= 1'b1;
              rom_addr_q <= {type_q, row_q, col_q};
            end else if (rom_ack_i) begin
              rom_req_q <= 1'b0;
              lb_we_q   <= (rom_data_i != TRANSPARENT) && visible;
              lb_addr_q <= pix_x[9:0];
              lb_data_q <= rom_data_i;
              state_q   <= StWrite;
            end
          end
          StWrite: begin
            lb_we_q <= 1'b0;
            col_q   <= col_q + 1'b1;
            if (col_q == '1) begin
              if (last_entry) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= StDone;
              end else begin
                idx_q   <= idx_q + 1'b1;
                state_q <= StScan;
              end
            end else begin
              state_q <= StFetch;
            end
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overrun_o  = overrun_q;
  assign rom_req_o  = rom_req_q;
  assign rom_addr_o = rom_addr_q;
  assign lb_we_o    = lb_we_q;
  assign lb_bank_o  = bank_q;
  assign lb_addr_o  = lb_addr_q;
  assign lb_data_o  = lb_data_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Bench for sprite_line_scheduler: table vectors, corner sequences and random tables
// checked against a per-pixel reference of the final line buffer.
module tb_sprite_line_scheduler;
  localparam int NS = 20;
  localparam logic [23:0] TR = 24'h000000;
  localparam logic [23:0] BG = 24'h000000;
`ifdef SPRITE_LINE_CLEAR_EN
  localparam int CLR_W = 640;
`else
  localparam int CLR_W = 0;
`endif

  logic            clk, rst, start;
  logic [9:0]      line;
  logic [24*NS-1:0] gl;
  logic            busy, done, overrun, rom_req;
  logic            rom_ack = 1'b0;
  logic [14:0]     rom_addr;
  logic [23:0]     rom_data;
  logic            lb_we, lb_bank;
  logic [9:0]      lb_addr;
  logic [23:0]     lb_data;

  sprite_line_scheduler dut (
    .clk_i(clk), .rst_i(rst), .gl_array_i(gl), .start_i(start), .line_i(line),
    .busy_o(busy), .done_o(done), .overrun_o(overrun), .rom_req_o(rom_req),
    .rom_addr_o(rom_addr), .rom_ack_i(rom_ack), .rom_data_i(rom_data),
    .lb_we_o(lb_we), .lb_bank_o(lb_bank), .lb_addr_o(lb_addr), .lb_data_o(lb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ln;
    int ia, ta, xa, ya;
    int ib, tb, xb, yb;
    logic [23:0] ca, cb;
    int reqs, spr_w, first, probe;
    logic [23:0] pval;
    int busy_cyc;
  } vec_t;

  vec_t vecs[8];
  int passed = 0, total = 0;
  logic [23:0] lb_mem [2][640];
  logic [23:0] snap [640];
  logic [23:0] exp_buf [640];
  logic [23:0] type_color [32];
  bit rand_mode = 1'b0;
  int exp_bank = 0, exp_reqs, exp_spr;
  int done_cnt = 0, wr_cnt = 0, busy_cnt = 0, mon_err = 0, lat = 0, cur_lat = 2;
  bit prev_req = 1'b0;
  logic [14:0] held_addr;
  logic [14:0] req_log [$];

  function automatic logic [23:0] rom_fn(input logic [14:0] a);
    logic [31:0] h;
    if (!rand_mode) return type_color[a[14:10]];
    h = {17'd0, a} * 32'h9E3779B1;
    if (h[27:26] == 2'b00) return TR;
    return (h[31:8] == 24'h0) ? 24'h000001 : h[31:8];
  endfunction

  // ROM responder and line-buffer / protocol monitor.
  always @(negedge clk) begin
    if (rst) begin
      rom_ack = 1'b0; lat = 0; prev_req = 1'b0;
    end else begin
      if (lb_we) begin
        wr_cnt++;
        if (lb_addr > 10'd639) mon_err++;
        else lb_mem[lb_bank][lb_addr] = lb_data;
      end
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (rom_req && !prev_req) begin
        req_log.push_back(rom_addr);
        held_addr = rom_addr;
      end else if (rom_req && rom_addr !== held_addr) mon_err++;
      if (rom_ack) rom_ack = 1'b0;
      else if (rom_req) begin
        if (lat >= cur_lat) begin
          rom_ack = 1'b1; rom_data = rom_fn(rom_addr); lat = 0;
          cur_lat = rand_mode ? int'($urandom_range(3, 0)) : 2;
        end else lat++;
      end
      prev_req = rom_req;
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic set_entry(input int i, input int t, input int x, input int y);
    gl[24*i +: 24] = {5'(t), 10'(x), 9'(y)};
  endtask

  task automatic load_vec(input vec_t v);
    gl = '0;
    for (int t = 0; t < 32; t++) type_color[t] = 24'h0;
    type_color[v.ta] = v.ca;
    type_color[v.tb] = v.cb;
    set_entry(v.ia, v.ta, v.xa, v.ya);
    set_entry(v.ib, v.tb, v.xb, v.yb);
  endtask

  task automatic pulse_start(input int ln);
    exp_bank ^= 1;
    for (int a = 0; a < 640; a++) snap[a] = lb_mem[exp_bank][a];
    line = 10'(ln); start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin step(); n++; end
    check(name, done, 1'b1);
  endtask

  // Reference: paint every hitting sprite in index order onto the starting buffer.
  task automatic compute_expected(input int ln);
    logic [23:0] e, p;
    logic [4:0] r5, c5;
    int t, x, y;
    exp_reqs = 0; exp_spr = 0;
    for (int a = 0; a < 640; a++) exp_buf[a] = (CLR_W != 0) ? BG : snap[a];
    for (int i = 0; i < NS; i++) begin
      e = gl[24*i +: 24];
      t = int'(e[23:19]); x = int'(e[18:9]); y = int'(e[8:0]);
      if (t != 0 && ln >= y && ln - y < 32) begin
        exp_reqs += 32;
        r5 = 5'(ln - y);
        for (int c = 0; c < 32; c++) begin
          c5 = 5'(c);
          p = rom_fn({5'(t), r5, c5});
          if (p !== TR && x + c < 640) begin exp_buf[x + c] = p; exp_spr++; end
        end
      end
    end
  endtask

  task automatic check_linebuf(input string name);
    int bad = 0;
    for (int a = 0; a < 640; a++) if (lb_mem[exp_bank][a] !== exp_buf[a]) bad++;
    check(name, bad, 0);
  endtask

  initial begin
    int b_done, b_req, b_wr, b_busy, bank0, ln;
    vecs[0] = '{60, 0, 3, 100, 50, 1, 0, 0, 0, 24'h00FF00, 24'h0, 32, 32, 3392, 131,
                24'h00FF00, -1};
    vecs[1] = '{60, 0, 3, 620, 50, 1, 0, 0, 0, 24'h00FF00, 24'h0, 32, 20, 3392, 639,
                24'h00FF00, -1};
    vecs[2] = '{60, 2, 1, 200, 50, 5, 2, 200, 40, 24'hFF0000, 24'h0000FF, 64, 64, 1344, 200,
                24'h0000FF, -1};
    vecs[3] = '{60, 2, 1, 200, 50, 5, 2, 200, 40, 24'hFF0000, 24'h000000, 64, 32, 1344, 215,
                24'hFF0000, -1};
    vecs[4] = '{49, 0, 3, 100, 50, 7, 0, 300, 49, 24'h00FF00, 24'h0, 0, 0, -1, -1,
                24'h0, CLR_W + NS};
    vecs[5] = '{82, 0, 3, 100, 50, 9, 0, 100, 82, 24'h00FF00, 24'h0, 0, 0, -1, -1,
                24'h0, CLR_W + NS};
    vecs[6] = '{81, 19, 6, 0, 50, 1, 0, 0, 0, 24'h123456, 24'h0, 32, 32, 7136, 0,
                24'h123456, -1};
    vecs[7] = '{0, 4, 5, 1000, 0, 1, 0, 0, 0, 24'hABCDEF, 24'h0, 32, 0, 5120, -1,
                24'h0, -1};

    rst = 1'b1; start = 1'b0; line = '0; gl = '0;
    for (int t = 0; t < 32; t++) type_color[t] = 24'h0;
    repeat (3) step();
    check("reset_outputs", {busy, done, overrun, rom_req, lb_we, lb_bank}, 6'b0);
    rst = 1'b0;
    step();

    for (int k = 0; k < 8; k++) begin
      load_vec(vecs[k]);
      b_done = done_cnt; b_req = req_log.size(); b_wr = wr_cnt; b_busy = busy_cnt;
      pulse_start(vecs[k].ln);
      wait_done($sformatf("v%0d_done_seen", k), 30000);
      step();
      compute_expected(vecs[k].ln);
      check($sformatf("v%0d_reqs", k), req_log.size() - b_req, vecs[k].reqs);
      check($sformatf("v%0d_sprite_writes", k), wr_cnt - b_wr - CLR_W, vecs[k].spr_w);
      if (vecs[k].first >= 0)
        check($sformatf("v%0d_first_addr", k), req_log[b_req], vecs[k].first);
      if (vecs[k].probe >= 0)
        check($sformatf("v%0d_probe", k), lb_mem[exp_bank][vecs[k].probe], vecs[k].pval);
      if (vecs[k].busy_cyc >= 0)
        check($sformatf("v%0d_busy_cycles", k), busy_cnt - b_busy, vecs[k].busy_cyc);
      check_linebuf($sformatf("v%0d_linebuf", k));
      check($sformatf("v%0d_done_count", k), done_cnt - b_done, 1);
      check($sformatf("v%0d_bank", k), lb_bank, exp_bank);
      check($sformatf("v%0d_overrun", k), overrun, 1'b0);
    end

    // Start landing in the DONE cycle is an ordinary start.
    load_vec(vecs[4]);
    b_done = done_cnt;
    pulse_start(49);
    wait_done("done_start_first", 5000);
    pulse_start(49);
    wait_done("done_start_second", 5000);
    step();
    check("done_start_overrun", overrun, 1'b0);
    check("done_start_pulses", done_cnt - b_done, 2);
    check("done_start_bank", lb_bank, exp_bank);

    // Restart 100 cycles into a render.
    load_vec(vecs[0]);
    b_done = done_cnt; bank0 = exp_bank;
    pulse_start(60);
    repeat (100) step();
    check("overrun_before", overrun, 1'b0);
    pulse_start(60);
    check("overrun_set", overrun, 1'b1);
    wait_done("overrun_done_seen", 30000);
    step();
    compute_expected(60);
    check("overrun_done_pulses", done_cnt - b_done, 1);
    check("overrun_bank_twice", lb_bank, bank0);
    check_linebuf("overrun_linebuf");
    pulse_start(60);
    wait_done("overrun_next_done", 30000);
    step();
    check("overrun_sticky", overrun, 1'b1);

    // Reset while a ROM request is outstanding.
    pulse_start(60);
    begin
      int n = 0;
      while (!rom_req && n < 3000) begin step(); n++; end
    end
    check("req_before_reset", rom_req, 1'b1);
    rst = 1'b1;
    #1;
    check("reset_mid_fetch", {rom_req, lb_we, busy, overrun, lb_bank}, 5'b0);
    exp_bank = 0;
    step();
    rst = 1'b0;
    b_req = req_log.size(); b_busy = busy_cnt;
    repeat (20) step();
    check("idle_after_reset", (busy_cnt - b_busy) + (req_log.size() - b_req), 0);

    // Random tables against the reference.
    rand_mode = 1'b1;
    for (int it = 0; it < 6; it++) begin
      gl = '0;
      ln = int'($urandom_range(479, 0));
      for (int i = 0; i < NS; i++) begin
        int t, x, y;
        t = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(31, 1));
        x = int'($urandom_range(660, 0));
        y = int'($urandom_range(511, 0));
        if ($urandom_range(2, 0) == 0)
          y = (ln >= 40) ? ln - int'($urandom_range(40, 0)) : int'($urandom_range(ln, 0));
        set_entry(i, t, x, y);
      end
      b_done = done_cnt; b_req = req_log.size(); b_wr = wr_cnt;
      pulse_start(ln);
      wait_done($sformatf("r%0d_done_seen", it), 40000);
      step();
      compute_expected(ln);
      check($sformatf("r%0d_reqs", it), req_log.size() - b_req, exp_reqs);
      check($sformatf("r%0d_writes", it), wr_cnt - b_wr - CLR_W, exp_spr);
      check_linebuf($sformatf("r%0d_linebuf", it));
      check($sformatf("r%0d_done_count", it), done_cnt - b_done, 1);
    end

    check("rom_protocol", mon_err, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Renders one scanline of sprites into a ping-pong line buffer while the other bank is displayed.
- On each line-start pulse it optionally clears the back bank, then scans the sprite table for sprites overlapping the target line.
- For each hit it fetches 32 pixels from the sprite ROM over a req/ack handshake and writes the opaque, on-screen ones.
- Sits between the sprite table (gl_array) and the sprite controller's line buffer / VGA pixel path.

Parameters:
- NUM_SPRITES, 20, number of sprite table entries.
- SPRITE_SIZE, 32, sprite width and height in pixels (power of 2).
- TRANSPARENT, 24'h000000, ROM colour that is never written.
- BG_COLOR, 24'h000000, clear colour.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- gl_array  in  24 x NUM_SPRITES  sprite entries: [23:19] type (0 = disabled), [18:9] x, [8:0] y
- start  in  1  one-cycle pulse: render line `line`
- line  in  10  target scanline, sampled on start
- busy  out  1  render in progress
- done  out  1  one-cycle pulse, line complete
- overrun  out  1  sticky: start seen while busy
- rom_req  out  1  sprite ROM read request
- rom_addr  out  15  {type[4:0], row[4:0], col[4:0]}
- rom_ack  in  1  ROM data valid
- rom_data  in  24  RGB pixel
- lb_we  out  1  line buffer write strobe
- lb_bank  out  1  bank being rendered (display uses ~lb_bank)
- lb_addr  out  10  pixel x, 0..639
- lb_data  out  24  RGB pixel

Behaviour:
- Reset (async):
  - All outputs 0; FSM returns to IDLE.
  - lb_bank = 0; overrun cleared. Reset is the only way to clear overrun.
  - Any in-flight ROM request is dropped.
- States: IDLE, CLEAR, SCAN, FETCH, WRITE, DONE.
- IDLE:
  - On start: latch line, toggle lb_bank, set busy.
  - Go to CLEAR (or SCAN if clear is compiled out).
- CLEAR:
  - One write per cycle, lb_addr 0..639, lb_data = BG_COLOR. Exactly 640 cycles.
  - Then SCAN with sprite index i = 0.
- SCAN (one entry per cycle):
  - Hit when type != 0, line >= y, and (line - y) < SPRITE_SIZE. Compare in 10 bits with y zero-extended.
  - On hit: latch type, x, row = line - y; col = 0; go to FETCH.
  - On miss: i++. After i = NUM_SPRITES-1, go to DONE.
- FETCH:
  - rom_req is high starting the cycle after entry.
  - rom_addr is held stable while req=1 and ack=0.
  - On the rom_ack cycle: capture rom_data, drop req next cycle, go to WRITE.
  - ROM latency is unbounded.
- WRITE (one cycle):
  - lb_we = 1 iff data != TRANSPARENT and x+col <= 639. Compute x+col in 11 bits; clipped pixels are skipped silently.
  - lb_addr = x+col.
  - col++. If col wraps to 0: i++, then SCAN, or DONE if it was the last entry. Otherwise back to FETCH.
- Priority: entries are written in ascending index, so a higher index overwrites a lower one (higher index is on top).
- DONE: one cycle, done=1, busy drops; go to IDLE.
- gl_array is read live during SCAN. The hit entry's fields are latched, so mid-sprite table changes do not tear that sprite.
- start while busy (not in IDLE):
  - Set overrun, abort the current render, latch the new line, toggle lb_bank.
  - Restart from CLEAR/SCAN on the next cycle; no done pulse for the aborted line.
- start in the DONE cycle is accepted as a normal start (no overrun).
- Back-to-back ROM accesses: at least 1 idle cycle of rom_req between requests (the WRITE cycle).

Optional Feature:
- SPRITE_LINE_CLEAR_EN
  - Defined: CLEAR state is present, and each render begins with 640 BG_COLOR writes.
  - Undefined: IDLE goes straight to SCAN, the bank retains old contents, and the first lb_we occurs at the earliest first sprite write.

Test Plan:
- Reset asserted mid-FETCH with rom_req=1 -> same cycle: rom_req=0, lb_we=0, busy=0, overrun=0, lb_bank=0. After release, the FSM idles until start.
- Entry 0 = {type 3, x 100, y 50}, others type 0; start with line=60; ROM acks 2 cycles after req and returns 24'h00FF00 -> 640 clear writes.
  - Then 32 requests with rom_addr = {3,10,col}, writes to lb_addr 100..131 with 24'h00FF00, and exactly one done pulse.
- Same sprite at x=620 -> writes only to 620..639. All 32 ROM reads still occur.
- Entries 2 and 5 overlap at x=200..231, ROM returning pixel 24'h0000FF for type of entry 5 -> final buffer 200..231 = entry 5 colour. Entry 5 pixels returning TRANSPARENT leave entry 2's colour.
- line=49 or line=82 vs y=50, and a type-0 entry at a matching y -> no ROM requests. SCAN lasts NUM_SPRITES cycles, then done.
- Second start 100 cycles into a render -> overrun=1 and stays set, lb_bank toggles twice, and only one done pulse (for the second line) is seen.
